// File: rtl/whac_pkg.sv
// Shared definitions for the whack-a-mole datapath: hole count, spawner states
// and the mole LFSR polynomial. Used by mole_spawner and hit_logic.
package whac_pkg;

  localparam int NUM_HOLES_DEF = 18;
  localparam int HOLE_IDX_W    = $clog2(NUM_HOLES_DEF);

  localparam int                LFSR_W    = 16;
  // Fibonacci taps 16,14,13,11 (1-based) -> bits 15,13,12,10
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef logic [1:0] spawn_state_t;
  localparam spawn_state_t ST_IDLE  = 2'd0;
  localparam spawn_state_t ST_PLACE = 2'd1;
  localparam spawn_state_t ST_UP    = 2'd2;
  localparam spawn_state_t ST_DOWN  = 2'd3;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; exposes only the low OUT_W bits that the
// spawner uses as a hole-index candidate.
module mole_lfsr
  import whac_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
  parameter int                OUT_W = HOLE_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [OUT_W-1:0] rnd
);

  logic [LFSR_W-1:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= SEED;
    else        lfsr <= lfsr_next(lfsr);
  end

  assign rnd = lfsr[OUT_W-1:0];

endmodule

// File: rtl/mole_spawner.sv
// Round sequencer: places NUM_MOLES distinct moles from the LFSR, holds them up
// (dropping whacked ones), then keeps the field empty for the down phase.
module mole_spawner
  import whac_pkg::*;
#(
  parameter int                NUM_HOLES    = NUM_HOLES_DEF,
  parameter int                NUM_MOLES    = 3,
  parameter int                MOLE_UP_MS   = 1000,
  parameter int                MOLE_DOWN_MS = 1000,
  parameter int                CLK_PER_MS   = 50000,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NUM_HOLES-1:0] hit_mask,
  output logic [NUM_HOLES-1:0] mole_positions,
  output logic                 round_start,
  output logic                 round_end,
  output logic                 all_cleared
);

  localparam int IDX_W  = $clog2(NUM_HOLES);
  localparam int PRE_W  = $clog2(CLK_PER_MS);
  localparam int MS_MAX = (MOLE_UP_MS > MOLE_DOWN_MS) ? MOLE_UP_MS : MOLE_DOWN_MS;
  localparam int MS_W   = $clog2(MS_MAX + 1);
  localparam int CNT_W  = $clog2(NUM_MOLES + 1);

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_PER_MS - 1);
  localparam logic [MS_W-1:0]  UP_LAST   = MS_W'(MOLE_UP_MS - 1);
  localparam logic [MS_W-1:0]  DOWN_LAST = MS_W'(MOLE_DOWN_MS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(NUM_MOLES);
  localparam logic [IDX_W:0]   HOLE_LIM  = (IDX_W+1)'(NUM_HOLES);

  spawn_state_t           state, state_d;
  logic [NUM_HOLES-1:0]   place_vec, place_d;
  logic [CNT_W-1:0]       placed_cnt, cnt_d, cnt_inc;
  logic [PRE_W-1:0]       pre_cnt, pre_d, pre_tick;
  logic [MS_W-1:0]        ms_cnt, ms_d, ms_tick;
  logic [NUM_HOLES-1:0]   pos_d, pos_hit, cand_bit, place_new;
  logic                   rs_d, re_d, ac_d;
  logic [IDX_W-1:0]       cand_idx;
  logic                   in_range, accept, pre_wrap, up_done, down_done;

  mole_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (IDX_W)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .rnd   (cand_idx)
  );

  // Candidate evaluation: out-of-range indices shift the one-hot bit away.
  assign in_range  = {1'b0, cand_idx} < HOLE_LIM;
  assign cand_bit  = {{(NUM_HOLES-1){1'b0}}, 1'b1} << cand_idx;
  assign accept    = in_range && ((place_vec & cand_bit) == '0);
  assign place_new = place_vec | cand_bit;
  assign cnt_inc   = placed_cnt + CNT_W'(1);

  // Phase timer: prescaler in clk cycles, ms_cnt in milliseconds.
  assign pre_wrap  = (pre_cnt == PRE_LAST);
  assign pre_tick  = pre_wrap ? '0 : pre_cnt + PRE_W'(1);
  assign ms_tick   = pre_wrap ? ms_cnt + MS_W'(1) : ms_cnt;
  assign up_done   = pre_wrap && (ms_cnt == UP_LAST);
  assign down_done = pre_wrap && (ms_cnt == DOWN_LAST);

  assign pos_hit   = mole_positions & ~hit_mask;

  always_comb begin
    state_d = state;
    place_d = place_vec;
    cnt_d   = placed_cnt;
    pre_d   = pre_cnt;
    ms_d    = ms_cnt;
    pos_d   = mole_positions;
    rs_d    = 1'b0;
    re_d    = 1'b0;
    ac_d    = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      pos_d   = '0;
      pre_d   = '0;
      ms_d    = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_d = ST_PLACE;
          place_d = '0;
          cnt_d   = '0;
          pos_d   = '0;
        end
        ST_PLACE: begin
          pos_d = '0;
          if (accept) begin
            place_d = place_new;
            cnt_d   = cnt_inc;
            if (cnt_inc == CNT_FULL) begin
              pos_d   = place_new;
              rs_d    = 1'b1;
              state_d = ST_UP;
              pre_d   = '0;
              ms_d    = '0;
            end
          end
        end
        ST_UP: begin
          pre_d = pre_tick;
          ms_d  = ms_tick;
          // A final hit coinciding with timeout still counts as a clear.
          if ((pos_hit == '0) || up_done) begin
            pos_d   = '0;
            re_d    = 1'b1;
            ac_d    = (pos_hit == '0);
            state_d = ST_DOWN;
            pre_d   = '0;
            ms_d    = '0;
          end else begin
            pos_d = pos_hit;
          end
        end
        ST_DOWN: begin
          pos_d = '0;
          pre_d = pre_tick;
          ms_d  = ms_tick;
          if (down_done) begin
            state_d = ST_PLACE;
            place_d = '0;
            cnt_d   = '0;
            pre_d   = '0;
            ms_d    = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          pos_d   = '0;
          pre_d   = '0;
          ms_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      place_vec      <= '0;
      placed_cnt     <= '0;
      pre_cnt        <= '0;
      ms_cnt         <= '0;
      mole_positions <= '0;
      round_start    <= 1'b0;
      round_end      <= 1'b0;
      all_cleared    <= 1'b0;
    end else begin
      state          <= state_d;
      place_vec      <= place_d;
      placed_cnt     <= cnt_d;
      pre_cnt        <= pre_d;
      ms_cnt         <= ms_d;
      mole_positions <= pos_d;
      round_start    <= rs_d;
      round_end      <= re_d;
      all_cleared    <= ac_d;
    end
  end

endmodule
